// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed 7-segment scan driver with per-frame input snapshot,
// leading-zero blanking, decimal points and a sticky overflow blink.
module seg_scan_driver #(
    parameter int unsigned SCAN_DIV     = 16,
    parameter int unsigned BLINK_FRAMES = 32
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_mask,
    input  logic        blank_lz,
    input  logic        overflow_in,
    input  logic        clear_ov,
    output logic [7:0]  LED,
    output logic [3:0]  selecters,
    output logic        frame_done
);

    localparam int unsigned PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] psc;
    logic [1:0]    idx;
    logic [15:0]   snap_digits;
    logic [3:0]    snap_dp;
    logic          snap_blz;
    logic [7:0]    seg_q;
    logic          ov;
    logic [7:0]    fcnt;
    logic          phase;

    logic          tick;
    logic          wrap;
    logic [1:0]    next_idx;
    logic [15:0]   src_digits;
    logic [3:0]    src_dp;
    logic          src_blz;
    logic [3:0]    nib;
    logic [7:0]    seg_next;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] n);
        case (n)
            4'd0:    bcd_to_seg = 7'h3F;
            4'd1:    bcd_to_seg = 7'h06;
            4'd2:    bcd_to_seg = 7'h5B;
            4'd3:    bcd_to_seg = 7'h4F;
            4'd4:    bcd_to_seg = 7'h66;
            4'd5:    bcd_to_seg = 7'h6D;
            4'd6:    bcd_to_seg = 7'h7D;
            4'd7:    bcd_to_seg = 7'h07;
            4'd8:    bcd_to_seg = 7'h7F;
            4'd9:    bcd_to_seg = 7'h6F;
            default: bcd_to_seg = 7'h40;
        endcase
    endfunction

    // True when digit i and every more significant digit are zero; digit 0 never qualifies.
    function automatic logic lead_zero(input logic [15:0] d, input logic [1:0] i);
        case (i)
            2'd3:    lead_zero = (d[15:12] == 4'h0);
            2'd2:    lead_zero = (d[15:8] == 8'h00);
            2'd1:    lead_zero = (d[15:4] == 12'h000);
            default: lead_zero = 1'b0;
        endcase
    endfunction

    always_comb begin
        tick     = (psc == PW'(SCAN_DIV - 1));
        wrap     = tick && (idx == 2'd3);
        next_idx = idx + 2'd1;
        // The wrap edge displays digit 0 straight from the inputs being captured.
        src_digits = wrap ? digits   : snap_digits;
        src_dp     = wrap ? dp_mask  : snap_dp;
        src_blz    = wrap ? blank_lz : snap_blz;
        nib        = src_digits[{next_idx, 2'b00} +: 4];
        seg_next   = {src_dp[next_idx],
                      (src_blz && lead_zero(src_digits, next_idx)) ? 7'h00 : bcd_to_seg(nib)};
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            psc         <= '0;
            idx         <= '0;
            selecters   <= 4'b0001;
            seg_q       <= '0;
            snap_digits <= '0;
            snap_dp     <= '0;
            snap_blz    <= 1'b0;
            ov          <= 1'b0;
            fcnt        <= '0;
            phase       <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= wrap;
            psc        <= tick ? '0 : psc + PW'(1);
            if (tick) begin
                idx       <= next_idx;
                selecters <= 4'b0001 << next_idx;
                seg_q     <= seg_next;
            end
            if (wrap) begin
                snap_digits <= digits;
                snap_dp     <= dp_mask;
                snap_blz    <= blank_lz;
            end
            ov <= overflow_in | (ov & ~clear_ov);
            if (!ov) begin
                fcnt  <= '0;
                phase <= 1'b0;
            end else if (wrap) begin
                if (fcnt == 8'(BLINK_FRAMES - 1)) begin
                    fcnt  <= '0;
                    phase <= ~phase;
                end else begin
                    fcnt <= fcnt + 8'd1;
                end
            end
        end
    end

    always_comb begin
        LED = (ov && phase) ? '0 : seg_q;
    end

endmodule
